// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: parametrised N-to-1 selector with a single registered output
// slot. Channels are chosen either by an explicit index or by a round-robin
// arbiter that resumes after the last served channel.
//
// Handshake: a beat moves from input channel k when valid_i[k] and ready_o[k]
// are both high on a rising edge; it leaves the slot when valid_o and ready_i
// are both high on a rising edge. ready_o never depends on the slot contents
// other than through can_load = !valid_o | ready_i, so a drain and a load may
// happen on the same edge with no bubble. Producers may drop valid at will.
module mux_nto1_pipe #(
    parameter int size   = 32,
    parameter int ch_num = 4,
    parameter int sel_w  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ch_num*size-1:0] data_i,
    input  logic [ch_num-1:0]      valid_i,
    output logic [ch_num-1:0]      ready_o,
    input  logic                   mode_i,
    input  logic [sel_w-1:0]       select_i,
    output logic [size-1:0]        data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [sel_w-1:0]       grant_o
);

    // Output slot and arbitration pointer
    logic [size-1:0]   r_data;
    logic              r_valid;
    logic [sel_w-1:0]  r_grant;
    logic [sel_w-1:0]  r_rr_ptr;

    // Combinational decisions for the current cycle
    logic              w_can_load;
    logic              w_hi_found;
    logic [sel_w-1:0]  w_hi_cand;
    logic              w_lo_found;
    logic [sel_w-1:0]  w_lo_cand;
    logic              w_rr_found;
    logic [sel_w-1:0]  w_rr_cand;
    logic [ch_num-1:0] w_ready;
    logic              w_xfer;
    logic [sel_w-1:0]  w_xfer_idx;
    logic [size-1:0]   w_xfer_data;

    // The slot can accept a beat when it is empty or is being drained now.
    assign w_can_load = !r_valid || ready_i;

    // Round-robin candidate: first valid channel above the pointer, otherwise
    // the first valid channel from 0 up to the pointer (wrap stays < ch_num).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_cand  = '0;
        w_lo_found = 1'b0;
        w_lo_cand  = '0;
        for (int k = 0; k < ch_num; k++) begin
            if (valid_i[k]) begin
                if (k > int'(r_rr_ptr)) begin
                    if (!w_hi_found) begin
                        w_hi_found = 1'b1;
                        w_hi_cand  = sel_w'(k);
                    end
                end else begin
                    if (!w_lo_found) begin
                        w_lo_found = 1'b1;
                        w_lo_cand  = sel_w'(k);
                    end
                end
            end
        end
        w_rr_found = w_hi_found || w_lo_found;
        w_rr_cand  = w_hi_found ? w_hi_cand : w_lo_cand;
    end

    // Per-channel ready: at most one bit, forced low during reset. An
    // out-of-range explicit select matches no channel, so nothing is ready.
    always_comb begin
        w_ready = '0;
        if (rst_i && w_can_load) begin
            for (int k = 0; k < ch_num; k++) begin
                if (mode_i) begin
                    if (w_rr_found && (w_rr_cand == sel_w'(k))) begin
                        w_ready[k] = 1'b1;
                    end
                end else if (int'(select_i) == k) begin
                    w_ready[k] = 1'b1;
                end
            end
        end
    end

    // Identify the channel completing a transfer this cycle and its data.
    always_comb begin
        w_xfer      = 1'b0;
        w_xfer_idx  = '0;
        w_xfer_data = '0;
        for (int k = 0; k < ch_num; k++) begin
            if (w_ready[k] && valid_i[k]) begin
                w_xfer      = 1'b1;
                w_xfer_idx  = sel_w'(k);
                w_xfer_data = data_i[k*size +: size];
            end
        end
    end

    // Slot and pointer update: load wins over drain; the pointer follows every
    // transfer in either mode so fairness carries across mode switches.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_grant  <= '0;
            r_rr_ptr <= sel_w'(ch_num - 1);
        end else if (w_xfer) begin
            r_data   <= w_xfer_data;
            r_valid  <= 1'b1;
            r_grant  <= w_xfer_idx;
            r_rr_ptr <= w_xfer_idx;
        end else if (ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    assign ready_o = w_ready;
    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign grant_o = r_grant;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: a 4-channel instance checked against a behavioural
// model, plus a 3-channel instance for the out-of-range select and wrap cases.
`timescale 1ns/1ps
module tb_mux_nto1_pipe;

    localparam int SIZE = 32;
    localparam int CH   = 4;
    localparam int SW   = 2;
    localparam int CH3  = 3;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Stimulus
    logic [CH*SIZE-1:0] data   = '0;
    logic [CH-1:0]      valid  = '0;
    logic               mode   = 1'b0;
    logic [SW-1:0]      sel    = '0;
    logic               rdy_in = 1'b0;

    // 4-channel DUT outputs
    logic [CH-1:0]   ready_o;
    logic [SIZE-1:0] data_o;
    logic            valid_o;
    logic [SW-1:0]   grant_o;

    // 3-channel DUT
    logic [CH3*SIZE-1:0] data3;
    logic [CH3-1:0]      valid3;
    logic [CH3-1:0]      ready3;
    logic [SIZE-1:0]     data3_o;
    logic                valid3_o;
    logic [SW-1:0]       grant3_o;
    assign data3  = data[CH3*SIZE-1:0];
    assign valid3 = valid[CH3-1:0];

    mux_nto1_pipe #(.size(SIZE), .ch_num(CH), .sel_w(SW)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
        .ready_o(ready_o), .mode_i(mode), .select_i(sel), .data_o(data_o),
        .valid_o(valid_o), .ready_i(rdy_in), .grant_o(grant_o)
    );

    mux_nto1_pipe #(.size(SIZE), .ch_num(CH3), .sel_w(SW)) dut3 (
        .clk_i(clk), .rst_i(rst), .data_i(data3), .valid_i(valid3),
        .ready_o(ready3), .mode_i(mode), .select_i(sel), .data_o(data3_o),
        .valid_o(valid3_o), .ready_i(rdy_in), .grant_o(grant3_o)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model of the 4-channel instance
    bit          m_valid;
    logic [31:0] m_data;
    int          m_grant;
    int          m_last;
    logic [3:0]  er;

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_grant = 0;
        m_last  = CH - 1;
    endtask

    // Which channel should be offered a transfer given the present inputs.
    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        r = '0;
        if (m_valid && !rdy_in) return r;
        if (mode == 1'b0) begin
            if (int'(sel) < CH) r[sel] = 1'b1;
        end else begin
            for (int off = 1; off <= CH; off++) begin
                int c;
                c = (m_last + off) % CH;
                if (valid[c]) begin
                    r[c] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    // Apply one clock edge to the model using the pre-edge inputs.
    task automatic model_advance(input logic [3:0] r);
        int ch;
        ch = -1;
        for (int k = 0; k < CH; k++) if (r[k] && valid[k]) ch = k;
        if (ch >= 0) begin
            m_valid = 1'b1;
            m_data  = data[ch*SIZE +: SIZE];
            m_grant = ch;
            m_last  = ch;
        end else if (rdy_in) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < CH; k++) data[k*SIZE +: SIZE] = $urandom();
    endtask

    task automatic test_reset();
        rst = 1'b0; mode = 1'b0; sel = '0; valid = 4'hF; rdy_in = 1'b1;
        rand_data();
        repeat (3) @(posedge clk);
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
        total++; if (grant_o !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_o); end
        total++; if (ready_o !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", ready_o); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_rr_wrap();
        int seq[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};
        mode = 1'b1; rdy_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_data();
            valid = (i >= 8) ? 4'b1010 : 4'b1111;
            #1;
            er = exp_ready();
            total++; if (ready_o !== er) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, ready_o, er); end
            @(posedge clk); model_advance(er); #1;
            total++; if (grant_o !== SW'(seq[i]) || valid_o !== 1'b1) begin
                bad++; $display("FAIL rr_grant[%0d]: got %0d/%b want %0d/1", i, grant_o, valid_o, seq[i]);
            end
            total++; if (data_o !== m_data) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", i, data_o, m_data); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        mode = 1'b1; rdy_in = 1'b1; valid = 4'b0010;
        rand_data();
        #1; er = exp_ready();
        @(posedge clk); model_advance(er); #1;
        held = data[1*SIZE +: SIZE];
        total++; if (grant_o !== 2'd1 || data_o !== held) begin
            bad++; $display("FAIL bp_load: got %0d/%h want 1/%h", grant_o, data_o, held);
        end
        rdy_in = 1'b0; valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1; er = exp_ready();
            total++; if (ready_o !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, ready_o); end
            @(posedge clk); model_advance(er); #1;
            total++; if (data_o !== held || grant_o !== 2'd1 || valid_o !== 1'b1) begin
                bad++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b want %h/1/1", i, data_o, grant_o, valid_o, held);
            end
        end
        rdy_in = 1'b1;
        #1; er = exp_ready();
        total++; if (ready_o !== 4'b0100) begin bad++; $display("FAIL bp_release_ready: got %b want 0100", ready_o); end
        held = data[2*SIZE +: SIZE];
        @(posedge clk); model_advance(er); #1;
        total++; if (grant_o !== 2'd2 || valid_o !== 1'b1 || data_o !== held) begin
            bad++; $display("FAIL bp_release: got %0d/%b/%h want 2/1/%h", grant_o, valid_o, data_o, held);
        end
    endtask

    task automatic test_explicit_stream();
        mode = 1'b0; sel = 2'd2; valid = 4'hF; rdy_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            if (i == 0) data[2*SIZE +: SIZE] = 32'hA5A5_0002;
            #1; er = exp_ready();
            total++; if (ready_o !== 4'b0100) begin bad++; $display("FAIL exp_ready[%0d]: got %b want 0100", i, ready_o); end
            @(posedge clk); model_advance(er); #1;
            total++; if (grant_o !== 2'd2 || valid_o !== 1'b1 || data_o !== m_data) begin
                bad++; $display("FAIL exp_out[%0d]: got %0d/%b/%h want 2/1/%h", i, grant_o, valid_o, data_o, m_data);
            end
            if (i == 0) begin
                total++; if (data_o !== 32'hA5A5_0002) begin bad++; $display("FAIL exp_first: got %h want a5a50002", data_o); end
            end
        end
    endtask

    task automatic test_mode_switch();
        mode = 1'b0; sel = 2'd3; valid = 4'hF; rdy_in = 1'b1;
        rand_data();
        #1; er = exp_ready();
        total++; if (ready_o !== 4'b1000) begin bad++; $display("FAIL ms_exp_ready: got %b want 1000", ready_o); end
        @(posedge clk); model_advance(er); #1;
        total++; if (grant_o !== 2'd3) begin bad++; $display("FAIL ms_exp_grant: got %0d want 3", grant_o); end
        mode = 1'b1;
        rand_data();
        #1; er = exp_ready();
        total++; if (ready_o !== 4'b0001) begin bad++; $display("FAIL ms_rr_ready: got %b want 0001", ready_o); end
        @(posedge clk); model_advance(er); #1;
        total++; if (grant_o !== 2'd0 || data_o !== data[0 +: SIZE]) begin
            bad++; $display("FAIL ms_rr_grant: got %0d/%h want 0/%h", grant_o, data_o, data[0 +: SIZE]);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] want;
        int          gseq[4] = '{0, 1, 2, 0};
        // drain the 3-channel slot
        mode = 1'b0; sel = 2'd0; valid = '0; rdy_in = 1'b1;
        #1; er = exp_ready();
        @(posedge clk); model_advance(er); #1;
        total++; if (valid3_o !== 1'b0) begin bad++; $display("FAIL oor_drain: got %b want 0", valid3_o); end
        sel = 2'd3; valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            #1; er = exp_ready();
            total++; if (ready3 !== 3'b000) begin bad++; $display("FAIL oor_ready[%0d]: got %b want 000", i, ready3); end
            @(posedge clk); model_advance(er); #1;
            total++; if (valid3_o !== 1'b0) begin bad++; $display("FAIL oor_valid[%0d]: got %b want 0", i, valid3_o); end
        end
        sel = 2'd2;
        rand_data();
        #1; er = exp_ready();
        total++; if (ready3 !== 3'b100) begin bad++; $display("FAIL oor_inrange_ready: got %b want 100", ready3); end
        want = data[2*SIZE +: SIZE];
        @(posedge clk); model_advance(er); #1;
        total++; if (valid3_o !== 1'b1 || grant3_o !== 2'd2 || data3_o !== want) begin
            bad++; $display("FAIL oor_inrange_load: got %b/%0d/%h want 1/2/%h", valid3_o, grant3_o, data3_o, want);
        end
        // round-robin on 3 channels must wrap from 2 back to 0
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            #1; er = exp_ready();
            want = data[gseq[i]*SIZE +: SIZE];
            @(posedge clk); model_advance(er); #1;
            total++; if (grant3_o !== SW'(gseq[i]) || data3_o !== want) begin
                bad++; $display("FAIL rr3_wrap[%0d]: got %0d/%h want %0d/%h", i, grant3_o, data3_o, gseq[i], want);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_data();
            mode   = 1'($urandom_range(0, 1));
            sel    = SW'($urandom_range(0, CH - 1));
            valid  = 4'($urandom_range(0, 15));
            rdy_in = ($urandom_range(0, 3) != 0);
            #1; er = exp_ready();
            total++; if (ready_o !== er) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, ready_o, er); end
            @(posedge clk); model_advance(er); #1;
            total++; if (valid_o !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, valid_o, m_valid); end
            total++; if (data_o !== m_data || grant_o !== SW'(m_grant)) begin
                bad++; $display("FAIL rnd_out[%0d]: got %h/%0d want %h/%0d", i, data_o, grant_o, m_data, m_grant);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        mode = 1'b1; valid = 4'hF; rdy_in = 1'b1;
        rand_data();
        #1; er = exp_ready();
        @(posedge clk); model_advance(er); #1;
        rdy_in = 1'b0;
        #1; er = exp_ready();
        @(posedge clk); model_advance(er); #1;
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", valid_o); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (valid_o !== 1'b0 || data_o !== 32'h0 || grant_o !== 2'd0) begin
            bad++; $display("FAIL rst_async: got %b/%h/%0d want 0/0/0", valid_o, data_o, grant_o);
        end
        total++; if (ready_o !== 4'b0000) begin bad++; $display("FAIL rst_async_ready: got %b want 0000", ready_o); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        rdy_in = 1'b1;
        rand_data();
        #1; er = exp_ready();
        total++; if (ready_o !== 4'b0001) begin bad++; $display("FAIL rst_first_ready: got %b want 0001", ready_o); end
        @(posedge clk); model_advance(er); #1;
        total++; if (grant_o !== 2'd0 || valid_o !== 1'b1 || data_o !== data[0 +: SIZE]) begin
            bad++; $display("FAIL rst_first_grant: got %0d/%b/%h want 0/1/%h", grant_o, valid_o, data_o, data[0 +: SIZE]);
        end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_rr_wrap();
        test_backpressure();
        test_explicit_stream();
        test_mode_switch();
        test_out_of_range();
        test_random();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
